// File: rtl/pdm_decoder_pkg.sv
// Shared audio constants and the decoder control state type.
// The DAC, the oscillator and this decoder all take their sample width and
// sample period from here, so they stay at one sample rate.
package pdm_decoder_pkg;

  // PCM width used by the whole audio path (DAC input, mixer, decoder output).
  localparam int AUDIO_BITDEPTH = 14;

  // System clock and the sample period expressed as a power of two in clocks.
  localparam int AUDIO_CLK_HZ       = 8_000_000;
  localparam int SAMPLE_PERIOD_LOG2 = 8;
  localparam int SAMPLE_RATE_HZ     = AUDIO_CLK_HZ >> SAMPLE_PERIOD_LOG2;

  // Decoder control: IDLE while enable is low, RUN while decoding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pdm_state_e;

endpackage

// File: rtl/pdm_window_counter.sv
// Front end of the PDM decoder: two-flop synchronizer on the raw bitstream,
// window position counter and ones accumulator. At the last cycle of each
// window it captures the window total (including that cycle's bit) and raises
// c_valid for one cycle, with c held until the next capture.
module pdm_window_counter
  import pdm_decoder_pkg::*;
#(
  parameter int DECIM_LOG2 = SAMPLE_PERIOD_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pdm_in,
  input  logic                  count_en,  // sample s2 this cycle
  input  logic                  clear,     // restart the window from zero
  output logic [DECIM_LOG2:0]   c,
  output logic                  c_valid
);

  localparam logic [DECIM_LOG2-1:0] WCNT_LAST = '1;
  localparam logic [DECIM_LOG2-1:0] WCNT_ONE  = {{(DECIM_LOG2-1){1'b0}}, 1'b1};

  logic                  s1_q, s1_d;
  logic                  s2_q, s2_d;
  logic [DECIM_LOG2-1:0] wcnt_q, wcnt_d;
  logic [DECIM_LOG2:0]   ones_q, ones_d;
  logic [DECIM_LOG2:0]   c_q, c_d;
  logic                  cap_q, cap_d;
  logic [DECIM_LOG2:0]   total;

  // Next-state: synchronizer shift, window count and accumulate, capture on the last cycle.
  always_comb begin
    s1_d   = pdm_in;
    s2_d   = s1_q;
    wcnt_d = wcnt_q;
    ones_d = ones_q;
    c_d    = c_q;
    cap_d  = 1'b0;
    total  = ones_q + {{DECIM_LOG2{1'b0}}, s2_q};
    if (clear) begin
      wcnt_d = '0;
      ones_d = '0;
    end else if (count_en) begin
      wcnt_d = wcnt_q + WCNT_ONE;
      if (wcnt_q == WCNT_LAST) begin
        // This cycle's bit goes into the captured total; the next window starts empty.
        ones_d = '0;
        c_d    = total;
        cap_d  = 1'b1;
      end else begin
        ones_d = total;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      wcnt_q <= '0;
      ones_q <= '0;
      c_q    <= '0;
      cap_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      wcnt_q <= wcnt_d;
      ones_q <= ones_d;
      c_q    <= c_d;
      cap_q  <= cap_d;
    end
  end

  assign c       = c_q;
  assign c_valid = cap_q;

endmodule

// File: rtl/pdm_decoder.sv
// PDM to PCM decoder: integrate-and-dump window (pdm_window_counter), then a
// 2-tap moving average of consecutive window totals, saturated and aligned to
// BITDEPTH bits. IDLE/RUN control follows enable.
// Output protocol: pcm is a registered sample; pcm_valid is a one-cycle strobe
// in the cycle pcm takes a new value. There is no back-pressure.
module pdm_decoder
  import pdm_decoder_pkg::*;
#(
  parameter int BITDEPTH   = AUDIO_BITDEPTH,
  parameter int DECIM_LOG2 = SAMPLE_PERIOD_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                pdm_in,
  output logic [BITDEPTH-1:0] pcm,
  output logic                pcm_valid
);

  localparam int SAT_W = DECIM_LOG2 + 1;

  pdm_state_e          state_q, state_d;
  logic [SAT_W-1:0]    prev_q, prev_d;
  logic [BITDEPTH-1:0] pcm_q, pcm_d;
  logic                pcm_valid_q, pcm_valid_d;

  logic                count_en;
  logic                clear;
  logic [SAT_W-1:0]    c;
  logic                c_valid;
  logic [SAT_W:0]      sum;
  logic [SAT_W-1:0]    s_sat;
  logic [BITDEPTH-1:0] aligned;
  logic                update;

  pdm_window_counter #(
    .DECIM_LOG2 (DECIM_LOG2)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .pdm_in   (pdm_in),
    .count_en (count_en),
    .clear    (clear),
    .c        (c),
    .c_valid  (c_valid)
  );

  // Control FSM: RUN counts while enable is high; entering RUN clears the window and history.
  always_comb begin
    state_d  = state_q;
    count_en = 1'b0;
    clear    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (enable) count_en = 1'b1;
        else        state_d  = ST_IDLE;
      end
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          clear   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Average of this and the previous window total, clamped to SAT_W bits.
  always_comb begin
    sum   = {1'b0, c} + {1'b0, prev_q};
    s_sat = sum[SAT_W] ? {SAT_W{1'b1}} : sum[SAT_W-1:0];
  end

  // Align the saturated sum to the PCM width: pad with zeros, or keep the top bits.
  if (BITDEPTH > SAT_W) begin : g_align_up
    assign aligned = {s_sat, {(BITDEPTH-SAT_W){1'b0}}};
  end else begin : g_align_down
    assign aligned = s_sat[SAT_W-1 -: BITDEPTH];
  end

  // A captured window only produces a sample if decoding is still enabled.
  assign update = c_valid && count_en;

  // Output and history update.
  always_comb begin
    prev_d      = prev_q;
    pcm_d       = pcm_q;
    pcm_valid_d = 1'b0;
    if (clear) begin
      prev_d = '0;
    end else if (update) begin
      prev_d      = c;
      pcm_d       = aligned;
      pcm_valid_d = 1'b1;
    end
  end

  // Registers. Reset state is RUN so counting begins on the first edge after
  // release when enable is already high; otherwise the FSM drops to IDLE there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      prev_q      <= '0;
      pcm_q       <= '0;
      pcm_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      pcm_q       <= pcm_d;
      pcm_valid_q <= pcm_valid_d;
    end
  end

  assign pcm       = pcm_q;
  assign pcm_valid = pcm_valid_q;

endmodule

// File: tb/tb_pdm_decoder.sv
// Testbench for pdm_decoder with default parameters (14-bit PCM, 256-clock window).
// Edge numbering: the first rising edge after rst_n release is edge 0.
module tb_pdm_decoder;

  localparam int BD  = 14;
  localparam int DL  = 8;
  localparam int WIN = 1 << DL;
  localparam int SAT = (1 << (DL + 1)) - 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          pdm_in = 1'b0;
  logic [BD-1:0] pcm;
  logic          pcm_valid;

  always #5 clk = ~clk;

  pdm_decoder #(
    .BITDEPTH   (BD),
    .DECIM_LOG2 (DL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .pdm_in    (pdm_in),
    .pcm       (pcm),
    .pcm_valid (pcm_valid)
  );

  // ---------------- bookkeeping ----------------
  int            total = 0;
  int            bad = 0;
  bit            in_pdm[$];
  bit            in_en[$];
  logic [BD-1:0] exp_q[$];
  int            exp_cyc[$];
  logic [BD-1:0] got_q[$];
  int            got_cyc[$];
  int            edge_cnt = 0;
  int            unstable_cnt = 0;
  logic [BD-1:0] last_pcm = '0;

  always @(posedge clk) begin
    if (rst_n) edge_cnt++;
  end

  // Monitor: record strobes with their edge index; count pcm changes without a strobe.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_pcm = pcm;
    end else begin
      if (pcm_valid) begin
        got_q.push_back(pcm);
        got_cyc.push_back(edge_cnt - 1);
      end else if (pcm !== last_pcm) begin
        unstable_cnt++;
      end
      last_pcm = pcm;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic assert_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    pdm_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Release reset at a falling edge with the inputs that edge 0 will see.
  task automatic release_reset(input bit p0, input bit e0);
    in_pdm.delete();
    in_en.delete();
    got_q.delete();
    got_cyc.delete();
    edge_cnt     = 0;
    unstable_cnt = 0;
    rst_n  = 1'b1;
    pdm_in = p0;
    enable = e0;
    in_pdm.push_back(p0);
    in_en.push_back(e0);
  endtask

  task automatic do_reset(input bit p0, input bit e0);
    assert_reset();
    release_reset(p0, e0);
  endtask

  // Set the inputs for the next edge.
  task automatic drive(input bit p, input bit e);
    @(negedge clk);
    pdm_in = p;
    enable = e;
    in_pdm.push_back(p);
    in_en.push_back(e);
  endtask

  // Let the last logged edge happen and its output be recorded.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Works on the logged inputs: the decoder sees each pdm bit two edges late
  // (zeros for edges 0 and 1), sums WIN sampled bits per window while running,
  // and one edge after a window closes emits min(c + prev, SAT) scaled to BD bits.
  function automatic void build_model();
    bit running = 1'b1;
    bit pending = 1'b0;
    int sum = 0;
    int n = 0;
    int prev = 0;
    int c = 0;
    exp_q.delete();
    exp_cyc.delete();
    for (int k = 0; k < in_en.size(); k++) begin
      bit b;
      bit en;
      bit closed;
      int s;
      b      = (k >= 2) ? in_pdm[k-2] : 1'b0;
      en     = in_en[k];
      closed = 1'b0;
      if (pending && en) begin
        s = c + prev;
        if (s > SAT) s = SAT;
        prev = c;
        exp_q.push_back(BD'(s << (BD - DL - 1)));
        exp_cyc.push_back(k);
      end
      if (running) begin
        if (en) begin
          sum += b;
          n++;
          if (n == WIN) begin
            c = sum;
            sum = 0;
            n = 0;
            closed = 1'b1;
          end
        end else begin
          running = 1'b0;
        end
      end else if (en) begin
        running = 1'b1;
        sum = 0;
        n = 0;
        prev = 0;
      end
      pending = closed;
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    assert_reset();
    total++;
    if (pcm !== '0) begin bad++; $display("FAIL reset_pcm: got %0d want 0", pcm); end
    total++;
    if (pcm_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", pcm_valid); end
  endtask

  task automatic test_const_zero();
    do_reset(1'b0, 1'b1);
    for (int k = 1; k < 4 * WIN + 10; k++) drive(1'b0, 1'b1);
    settle();
    build_model();
    total++;
    if (got_q.size() !== 4) begin bad++; $display("FAIL zero_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      total++;
      if (got_cyc[i] !== (i + 1) * WIN || got_q[i] !== '0) begin
        bad++;
        $display("FAIL zero_strobe[%0d]: got cyc=%0d pcm=%0d want cyc=%0d pcm=0", i, got_cyc[i], got_q[i], (i + 1) * WIN);
      end
    end
  endtask

  task automatic test_const_one();
    int want[3] = '{8128, 16320, 16352};
    do_reset(1'b1, 1'b1);
    for (int k = 1; k < 3 * WIN + 100; k++) drive(1'b1, 1'b1);
    settle();
    total++;
    if (got_q.size() !== 3) begin bad++; $display("FAIL one_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      total++;
      if (got_q[i] !== BD'(want[i]) || got_cyc[i] !== (i + 1) * WIN) begin
        bad++;
        $display("FAIL one_seq[%0d]: got pcm=%0d cyc=%0d want pcm=%0d cyc=%0d", i, got_q[i], got_cyc[i], want[i], (i + 1) * WIN);
      end
    end
  endtask

  // Follows test_const_one: reset mid-window must clear the outputs with no clock edge.
  task automatic test_async_reset();
    int want[3] = '{8128, 16320, 16352};
    total++;
    if (pcm !== BD'(16352)) begin bad++; $display("FAIL areset_pre: got %0d want 16352", pcm); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (pcm !== '0 || pcm_valid !== 1'b0) begin
      bad++;
      $display("FAIL areset_now: got pcm=%0d valid=%0b want 0/0", pcm, pcm_valid);
    end
    repeat (2) @(negedge clk);
    release_reset(1'b1, 1'b1);
    for (int k = 1; k < 3 * WIN + 20; k++) drive(1'b1, 1'b1);
    settle();
    total++;
    if (got_q.size() !== 3) begin bad++; $display("FAIL areset_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      total++;
      if (got_q[i] !== BD'(want[i])) begin
        bad++;
        $display("FAIL areset_seq[%0d]: got %0d want %0d", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_alternating();
    do_reset(1'b1, 1'b1);
    for (int k = 1; k < 5 * WIN + 10; k++) drive(k % 2 == 0, 1'b1);
    settle();
    build_model();
    total++;
    if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL alt_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 2; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== BD'(8192)) begin bad++; $display("FAIL alt_steady[%0d]: got %0d want 8192", i, got_q[i]); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_cyc[i] !== exp_cyc[i]) begin
        bad++;
        $display("FAIL alt_model[%0d]: got pcm=%0d cyc=%0d want pcm=%0d cyc=%0d", i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
  endtask

  // 25% density pattern as produced by the DAC for a mid-low code of 4096.
  task automatic test_loopback();
    int diff;
    do_reset(1'b1, 1'b1);
    for (int k = 1; k < 5 * WIN + 10; k++) drive(k % 4 == 0, 1'b1);
    settle();
    total++;
    if (got_q.size() !== 5) begin bad++; $display("FAIL loop_count: got %0d want 5", got_q.size()); end
    for (int i = 2; i < got_q.size(); i++) begin
      diff = int'(got_q[i]) - 4096;
      total++;
      if (diff > 64 || diff < -64) begin bad++; $display("FAIL loop_level[%0d]: got %0d want 4096+-64", i, got_q[i]); end
    end
  endtask

  // enable low from window cycle 100 of the third window for 50 cycles.
  task automatic test_enable_gap();
    int drop_k = 2 * WIN + 100;
    int up_k   = drop_k + 50;
    int strobes_in_gap = 0;
    int idx = -1;
    do_reset(1'b1, 1'b1);
    for (int k = 1; k < up_k + WIN + 40; k++) begin
      drive(1'b1, !(k >= drop_k && k < up_k));
      if (k == drop_k + 30) begin
        total++;
        if (pcm !== BD'(16320)) begin bad++; $display("FAIL gap_hold: got %0d want 16320", pcm); end
      end
    end
    settle();
    build_model();
    for (int i = 0; i < got_cyc.size(); i++) begin
      if (got_cyc[i] >= drop_k && got_cyc[i] < up_k + WIN + 1) strobes_in_gap++;
      if (got_cyc[i] == up_k + WIN + 1) idx = i;
    end
    total++;
    if (strobes_in_gap !== 0) begin bad++; $display("FAIL gap_quiet: got %0d strobes want 0", strobes_in_gap); end
    total++;
    if (idx < 0) begin
      bad++;
      $display("FAIL gap_restart: got no strobe at cycle %0d want one", up_k + WIN + 1);
    end else if (got_q[idx] !== BD'(8192)) begin
      bad++;
      $display("FAIL gap_restart: got %0d want 8192", got_q[idx]);
    end
    total++;
    if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL gap_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_cyc[i] !== exp_cyc[i]) begin
        bad++;
        $display("FAIL gap_model[%0d]: got pcm=%0d cyc=%0d want pcm=%0d cyc=%0d", i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
  endtask

  // Random density per window with random enable drops, against the model.
  task automatic test_random();
    int dens;
    int low_left;
    for (int r = 0; r < 3; r++) begin
      do_reset(1'($urandom_range(0, 1)), 1'b1);
      dens = $urandom_range(0, 100);
      low_left = 0;
      for (int k = 1; k < 1300; k++) begin
        if (k % WIN == 0) dens = $urandom_range(0, 100);
        if (low_left > 0) low_left--;
        else if ($urandom_range(0, 299) == 0) low_left = $urandom_range(1, 40);
        drive($urandom_range(0, 99) < dens, low_left == 0);
      end
      settle();
      build_model();
      total++;
      if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count[%0d]: got %0d want %0d", r, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i] || got_cyc[i] !== exp_cyc[i]) begin
          bad++;
          $display("FAIL rand_model[%0d/%0d]: got pcm=%0d cyc=%0d want pcm=%0d cyc=%0d", r, i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
        end
      end
      total++;
      if (unstable_cnt !== 0) begin bad++; $display("FAIL rand_stable[%0d]: got %0d changes without strobe want 0", r, unstable_cnt); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_const_zero();
    test_const_one();
    test_async_reset();
    test_alternating();
    test_loopback();
    test_enable_gap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
